score_seg_tx: RTL and testbench
===============================

Name: score_seg_tx

Overview:
- Consumer side of the 12-bit, 3-digit BCD score produced by the score accumulator.
- Converts the score into an 8-digit seven-segment frame with leading-zero blanking.
- Shifts the frame serially into the board's external shift-register display chain (clock, data, output-enable, clear).
- Retransmits automatically whenever the score changes.

Parameters:
- CLK_DIV, 4: system clocks per seg_clk half-period; legal range is 1 or greater.
- FRAME_BITS, 64: frame length, 8 digits × 8 segments; fixed, not for override.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- score  in  12  BCD score; [11:8] hundreds, [7:4] tens, [3:0] units
- force  in  1  one-cycle pulse requesting retransmission of the current score
- seg_clk  out  1  serial shift clock to the display chain
- seg_sout  out  1  serial data, MSB of frame first
- seg_pen  out  1  display output enable
- seg_clrn  out  1  display chain clear, active-low
- busy  out  1  high while a frame is in flight

Behaviour:
- Reset: rst is asynchronous, active-high.
  - While rst is high: seg_clk=0, seg_sout=1, seg_pen=0, seg_clrn=0, busy=0, state=IDLE, dirty=1, bit counter=0, divider=0.
  - seg_clrn rises on the first clk edge after rst deasserts.
  - Reset asserted mid-frame aborts the frame immediately. The display is re-sent from scratch after release.
- Segment code: active-low byte, bit7=dp … bit6=g … bit0=a; dp is always 1 (off).
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Non-BCD nibble (A–F) = BF (dash). Blank = FF.
- Frame layout: frame[63:56]=digit7 … frame[7:0]=digit0.
  - Digits 7..3 are always FF.
  - digit2: blank if the hundreds nibble is 0, else its code.
  - digit1: blank if both hundreds and tens are 0, else its code.
  - digit0: always shown.
  - A non-zero invalid nibble is never blanked; it shows as a dash.
- FSM states: IDLE, LOAD, SHIFT, LATCH.
  - IDLE → LOAD when dirty=1, or force=1, or score≠last_sent.
    - busy=0 in IDLE.
    - seg_clk=0 in IDLE.
    - seg_sout holds its last value in IDLE.
  - LOAD (1 cycle):
    - Capture score into last_sent.
    - Build the 64-bit frame into the shift register.
    - Clear dirty, busy=1.
  - SHIFT: one bit per 2×CLK_DIV clocks.
    - First CLK_DIV clocks: seg_clk=0 with seg_sout=frame[63].
    - Next CLK_DIV clocks: seg_clk=1.
    - Then shift left by one.
    - After the 64th rising edge of seg_clk completes its high phase, go to LATCH.
  - LATCH (1 cycle): seg_clk=0, seg_pen=1 (stays 1 until reset), then IDLE.
- Frame latency: LOAD to IDLE = 1 + 128×CLK_DIV + 1 clocks.
- Exactly 64 seg_clk rising edges per frame.
- seg_sout is stable for the whole high phase of seg_clk.
- Score change during SHIFT:
  - The current frame completes with the captured value.
  - IDLE then detects the mismatch and sends a new frame; no glitch, no abort.
- force during SHIFT/LATCH is ignored.
- Unchanged score and no force: no traffic (seg_clk stays 0).

Decomposition:
- Shared package:
  - segment constants (SEG_0..SEG_9, SEG_DASH=8'hBF, SEG_BLANK=8'hFF)
  - FRAME_BITS=64
  - state encoding (IDLE, LOAD, SHIFT, LATCH)
- One sub-module, seg_decode: combinational 4-bit nibble plus blank flag → 8-bit active-low pattern.
  - Instantiated three times for the score digits.
- The top holds the FSM, divider, bit counter, frame register, last_sent and dirty.

Test Plan (CLK_DIV=2 → 258 clocks per frame incl. LOAD/LATCH):
- Reset release, score=12'h000 → one frame.
  - Bits captured on seg_clk rising edges = 56 ones then C0.
  - Exactly 64 edges; then seg_pen=1, busy=0.
- score=12'h105 after idle → frame digits2..0 = F9,C0,92, upper five bytes FF.
  - Frame latency 258 clocks from the IDLE-detect cycle.
- score=12'h016 → digits2..0 = FF,F9,82. score=12'h0A0 → FF,BF,C0. score=12'h000 → FF,FF,C0.
- Score changes 12'h001→12'h004 at bit 20 of a frame → first frame completes showing F9 in digit0; a second frame follows showing 99. Total 128 seg_clk edges.
- Idle with constant score for 1000 clocks → no seg_clk edges. force pulse → exactly one frame identical to the previous one.
- rst pulsed at bit 30 of a frame → outputs immediately return to the reset values. After release a full fresh frame is sent; seg_pen=0 until its LATCH.

Source files
------------

// File: rtl/score_seg_tx_pkg.sv
// Shared constants for the score display transmitter: active-low segment
// patterns, frame length and FSM state encoding.
package score_seg_tx_pkg;

    localparam int FRAME_BITS = 64;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    // Non-BCD nibbles render as a dash so a corrupted score is visible.
    function automatic logic [7:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_code = SEG_0;
            4'd1:    seg_code = SEG_1;
            4'd2:    seg_code = SEG_2;
            4'd3:    seg_code = SEG_3;
            4'd4:    seg_code = SEG_4;
            4'd5:    seg_code = SEG_5;
            4'd6:    seg_code = SEG_6;
            4'd7:    seg_code = SEG_7;
            4'd8:    seg_code = SEG_8;
            4'd9:    seg_code = SEG_9;
            default: seg_code = SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/score_seg_tx_seg_decode.sv
// One display digit: BCD nibble plus blank request to an active-low
// seven-segment byte (dp always off).
module score_seg_tx_seg_decode
    import score_seg_tx_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    assign seg_o = blank_i ? SEG_BLANK : seg_code(nib_i);

endmodule

// File: rtl/score_seg_tx.sv
// Serialises the 3-digit BCD score into the 8-digit shift-register display
// chain, retransmitting whenever the score changes or a resend is requested.
module score_seg_tx
    import score_seg_tx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] score_i,
    input  logic        force_i,
    output logic        seg_clk_o,
    output logic        seg_sout_o,
    output logic        seg_pen_o,
    output logic        seg_clrn_o,
    output logic        busy_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    logic [1:0]            state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  sclk_q, sclk_d;
    logic                  sout_q, sout_d;
    logic                  pen_q, pen_d;
    logic                  dirty_q, dirty_d;
    logic                  clrn_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic [11:0]           last_q;
    logic                  load_frame, shift_frame;

    logic [7:0]            dig2, dig1, dig0;
    logic [FRAME_BITS-1:0] frame_new;
    logic                  hund_zero, tens_zero;

    assign hund_zero = (score_i[11:8] == 4'd0);
    assign tens_zero = (score_i[7:4] == 4'd0);

    score_seg_tx_seg_decode u_dec2 (
        .nib_i   (score_i[11:8]),
        .blank_i (hund_zero),
        .seg_o   (dig2)
    );

    score_seg_tx_seg_decode u_dec1 (
        .nib_i   (score_i[7:4]),
        .blank_i (hund_zero && tens_zero),
        .seg_o   (dig1)
    );

    score_seg_tx_seg_decode u_dec0 (
        .nib_i   (score_i[3:0]),
        .blank_i (1'b0),
        .seg_o   (dig0)
    );

    assign frame_new = {{5{SEG_BLANK}}, dig2, dig1, dig0};

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sclk_d      = sclk_q;
        sout_d      = sout_q;
        pen_d       = pen_q;
        dirty_d     = dirty_q;
        load_frame  = 1'b0;
        shift_frame = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dirty_q || force_i || (score_i != last_q)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // MSB goes straight to the pin; the register keeps the rest.
                load_frame = 1'b1;
                dirty_d    = 1'b0;
                sout_d     = frame_new[FRAME_BITS-1];
                div_d      = '0;
                bit_d      = '0;
                sclk_d     = 1'b0;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            pen_d   = 1'b1;
                            state_d = ST_LATCH;
                        end else begin
                            shift_frame = 1'b1;
                            sout_d      = frame_q[FRAME_BITS-1];
                            bit_d       = bit_q + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_LATCH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            sout_q  <= 1'b1;
            pen_q   <= 1'b0;
            dirty_q <= 1'b1;
            clrn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            sout_q  <= sout_d;
            pen_q   <= pen_d;
            dirty_q <= dirty_d;
            clrn_q  <= 1'b1;
        end
    end

    // Data-only registers; dirty forces a resend after reset, so no reset needed.
    always_ff @(posedge clk) begin
        if (load_frame) begin
            frame_q <= {frame_new[FRAME_BITS-2:0], 1'b0};
            last_q  <= score_i;
        end else if (shift_frame) begin
            frame_q <= {frame_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign seg_clk_o  = sclk_q;
    assign seg_sout_o = sout_q;
    assign seg_pen_o  = pen_q;
    assign seg_clrn_o = clrn_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_score_seg_tx.sv
// Bench for score_seg_tx: captures the serial stream on seg_clk rising edges
// and compares each frame against a digit-level model of the display.
module tb_score_seg_tx;

    localparam int TB_DIV = 2;
    localparam int FRAME_LAT = 2 + 128 * TB_DIV;
    localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] score_i = 12'h000;
    logic        force_i = 1'b0;
    logic        seg_clk_o, seg_sout_o, seg_pen_o, seg_clrn_o, busy_o;

    int total = 0;
    int bad = 0;

    logic [63:0] cap = '0;
    int          edges = 0;
    int          unstable = 0;
    logic        prev_sclk = 1'b0;
    logic        hold_bit = 1'b0;
    logic [11:0] last_sent = 12'h000;

    score_seg_tx #(.CLK_DIV(TB_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .score_i    (score_i),
        .force_i    (force_i),
        .seg_clk_o  (seg_clk_o),
        .seg_sout_o (seg_sout_o),
        .seg_pen_o  (seg_pen_o),
        .seg_clrn_o (seg_clrn_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (seg_clk_o && !prev_sclk) begin
            cap = {cap[62:0], seg_sout_o};
            edges++;
            hold_bit = seg_sout_o;
        end else if (seg_clk_o && (seg_sout_o !== hold_bit)) begin
            unstable++;
        end
        prev_sclk = seg_clk_o;
    end

    function automatic logic [7:0] digit_code(input int n);
        if (n <= 9) return SEG_TAB[n];
        return 8'hBF;
    endfunction

    function automatic logic [63:0] model_frame(input logic [11:0] s);
        int h, t, u;
        logic [7:0] d2, d1, d0;
        h  = int'(s) / 256;
        t  = (int'(s) / 16) % 16;
        u  = int'(s) % 16;
        d2 = (h == 0) ? 8'hFF : digit_code(h);
        d1 = (h == 0 && t == 0) ? 8'hFF : digit_code(t);
        d0 = digit_code(u);
        return {40'hFF_FFFF_FFFF, d2, d1, d0};
    endfunction

    task automatic run_frame(input int chg_at, input logic [11:0] chg_val,
                             input int frc_at, output int lat, output int pen_cnt);
        int n;
        bit fdone;
        n = 0; lat = 0; pen_cnt = 0; fdone = 0;
        while (busy_o !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        while (busy_o === 1'b1 && lat < 2000) begin
            if (seg_pen_o) pen_cnt++;
            if (edges == chg_at) score_i = chg_val;
            if (force_i) begin
                force_i = 1'b0;
                fdone = 1;
            end else if (edges == frc_at && !fdone) begin
                force_i = 1'b1;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (seg_clk_o !== 1'b0) begin bad++; $display("FAIL rst_sclk got=%b want=0", seg_clk_o); end
        total++; if (seg_sout_o !== 1'b1) begin bad++; $display("FAIL rst_sout got=%b want=1", seg_sout_o); end
        total++; if (seg_pen_o !== 1'b0) begin bad++; $display("FAIL rst_pen got=%b want=0", seg_pen_o); end
        total++; if (seg_clrn_o !== 1'b0) begin bad++; $display("FAIL rst_clrn got=%b want=0", seg_clrn_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_o); end
        cap = '0; edges = 0; unstable = 0;
        rst = 1'b0;
        #1;
        total++; if (seg_clrn_o !== 1'b0) begin bad++; $display("FAIL clrn_before_edge got=%b want=0", seg_clrn_o); end
        @(negedge clk);
        total++; if (seg_clrn_o !== 1'b1) begin bad++; $display("FAIL clrn_after_edge got=%b want=1", seg_clrn_o); end
    endtask

    task automatic test_first_frame();
        int lat, pc;
        run_frame(-1, 12'h000, -1, lat, pc);
        last_sent = 12'h000;
        total++; if (edges != 64) begin bad++; $display("FAIL first_edges got=%0d want=64", edges); end
        total++; if (cap !== model_frame(12'h000)) begin bad++; $display("FAIL first_frame got=%h want=%h", cap, model_frame(12'h000)); end
        total++; if (lat != FRAME_LAT) begin bad++; $display("FAIL first_lat got=%0d want=%0d", lat, FRAME_LAT); end
        total++; if (seg_pen_o !== 1'b1) begin bad++; $display("FAIL first_pen got=%b want=1", seg_pen_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL first_busy got=%b want=0", busy_o); end
        total++; if (unstable != 0) begin bad++; $display("FAIL first_stable got=%0d want=0", unstable); end
    endtask

    task automatic send_check(input logic [11:0] s);
        int lat, pc;
        cap = '0; edges = 0;
        @(negedge clk);
        score_i = s;
        run_frame(-1, 12'h000, -1, lat, pc);
        last_sent = s;
        total++; if (cap !== model_frame(s)) begin bad++; $display("FAIL frame_%h got=%h want=%h", s, cap, model_frame(s)); end
        total++; if (edges != 64) begin bad++; $display("FAIL edges_%h got=%0d want=64", s, edges); end
        total++; if (lat != FRAME_LAT) begin bad++; $display("FAIL lat_%h got=%0d want=%0d", s, lat, FRAME_LAT); end
    endtask

    task automatic test_patterns();
        logic [11:0] s;
        for (int i = 0; i < 5; i++) begin
            s = 12'($urandom_range(0, 4095));
            if (s == last_sent || s == 12'h105) s = s ^ 12'h011;
            send_check(s);
        end
        send_check(12'h105);
        send_check(12'h016);
        send_check(12'h0A0);
        send_check(12'h000);
        total++; if (unstable != 0) begin bad++; $display("FAIL pattern_stable got=%0d want=0", unstable); end
    endtask

    task automatic test_change_mid();
        int lat, pc;
        cap = '0; edges = 0;
        @(negedge clk);
        score_i = 12'h001;
        run_frame(20, 12'h004, -1, lat, pc);
        total++; if (cap !== model_frame(12'h001)) begin bad++; $display("FAIL chg_first got=%h want=%h", cap, model_frame(12'h001)); end
        total++; if (edges != 64) begin bad++; $display("FAIL chg_first_edges got=%0d want=64", edges); end
        run_frame(-1, 12'h000, -1, lat, pc);
        last_sent = 12'h004;
        total++; if (cap !== model_frame(12'h004)) begin bad++; $display("FAIL chg_second got=%h want=%h", cap, model_frame(12'h004)); end
        total++; if (edges != 128) begin bad++; $display("FAIL chg_total_edges got=%0d want=128", edges); end
    endtask

    task automatic test_idle_force();
        int lat, pc, busy_seen;
        cap = '0; edges = 0; busy_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy_o) busy_seen++;
        end
        total++; if (edges != 0) begin bad++; $display("FAIL idle_edges got=%0d want=0", edges); end
        total++; if (busy_seen != 0) begin bad++; $display("FAIL idle_busy got=%0d want=0", busy_seen); end
        total++; if (seg_clk_o !== 1'b0) begin bad++; $display("FAIL idle_sclk got=%b want=0", seg_clk_o); end
        force_i = 1'b1;
        @(negedge clk);
        force_i = 1'b0;
        run_frame(-1, 12'h000, 10, lat, pc);
        total++; if (cap !== model_frame(last_sent)) begin bad++; $display("FAIL resend_frame got=%h want=%h", cap, model_frame(last_sent)); end
        total++; if (lat != FRAME_LAT) begin bad++; $display("FAIL resend_lat got=%0d want=%0d", lat, FRAME_LAT); end
        repeat (400) @(negedge clk);
        total++; if (edges != 64) begin bad++; $display("FAIL resend_ignored got=%0d want=64", edges); end
    endtask

    task automatic test_reset_mid();
        int n, lat, pc;
        cap = '0; edges = 0; n = 0;
        @(negedge clk);
        score_i = 12'h789;
        while (edges < 30 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        total++; if (edges != 30) begin bad++; $display("FAIL mid_reach got=%0d want=30", edges); end
        #3 rst = 1'b1;
        #1;
        total++; if (seg_clk_o !== 1'b0) begin bad++; $display("FAIL mid_rst_sclk got=%b want=0", seg_clk_o); end
        total++; if (seg_sout_o !== 1'b1) begin bad++; $display("FAIL mid_rst_sout got=%b want=1", seg_sout_o); end
        total++; if (seg_pen_o !== 1'b0) begin bad++; $display("FAIL mid_rst_pen got=%b want=0", seg_pen_o); end
        total++; if (seg_clrn_o !== 1'b0) begin bad++; $display("FAIL mid_rst_clrn got=%b want=0", seg_clrn_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy_o); end
        repeat (4) @(negedge clk);
        cap = '0; edges = 0;
        rst = 1'b0;
        run_frame(-1, 12'h000, -1, lat, pc);
        last_sent = 12'h789;
        total++; if (cap !== model_frame(12'h789)) begin bad++; $display("FAIL fresh_frame got=%h want=%h", cap, model_frame(12'h789)); end
        total++; if (edges != 64) begin bad++; $display("FAIL fresh_edges got=%0d want=64", edges); end
        total++; if (lat != FRAME_LAT) begin bad++; $display("FAIL fresh_lat got=%0d want=%0d", lat, FRAME_LAT); end
        total++; if (pc != 1) begin bad++; $display("FAIL fresh_pen_cycles got=%0d want=1", pc); end
        total++; if (seg_pen_o !== 1'b1) begin bad++; $display("FAIL fresh_pen_end got=%b want=1", seg_pen_o); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_patterns();
        test_change_mid();
        test_idle_force();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
